// File: rtl/clkgen_multi.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | clkgen_multi: NUM_CH glitch-free divided clocks, per-channel div/phase/en |
// | applied at period boundaries. Macro CLKGEN_SYNC_RESTART_EN adds restart.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module clkgen_multi #(
  parameter int                NUM_CH        = 4,
  parameter int                DIV_W         = 8,
  parameter int                DEFAULT_DIV   = 2,
  parameter logic [NUM_CH-1:0] RESET_EN_MASK = '1,
  localparam int               CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
`ifdef CLKGEN_SYNC_RESTART_EN
  input  logic              restart,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int PAD_W = 2 ** CH_W;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DELAY = 2'd1, ST_RUN = 2'd2} state_t;

  logic [NUM_CH-1:0] pending;
  logic [PAD_W-1:0]  pend_pad;
  logic [DIV_W-1:0]  new_div;
  logic [DIV_W-1:0]  new_phase;

  // Unused channel codes read as "not pending", so out-of-range requests are accepted and dropped.
  assign pend_pad  = PAD_W'(pending);
  assign cfg_ready = ~pend_pad[cfg_ch];

  assign new_div   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign new_phase = (cfg_phase >= new_div) ? (new_div - DIV_W'(1)) : cfg_phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) locked <= 1'b1;
    else        locked <= ~|pending;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, phase_q, phase_d;
    logic [DIV_W-1:0] sh_div_q, sh_phase_q, pos;
    logic [DIV_W:0]   half;
    logic             en_q, en_d, sh_en_q, pend_q, pend_d;
    logic             acc, apply, show, clk_q, clk_d, tick_q, tick_d;

    assign acc        = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    assign pending[i] = pend_q;
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;

    // cnt holds the period position to be driven at the next edge (or remaining delay in DELAY);
    // show/pos describe what the output register takes at this edge.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      phase_d = phase_q;
      en_d    = en_q;
      pend_d  = pend_q;
      show    = 1'b0;
      pos     = '0;
      apply   = (state_q == ST_RUN) ? (pend_q && cnt_q == '0) : pend_q;
`ifdef CLKGEN_SYNC_RESTART_EN
      apply   = apply | restart;
`endif
      if (apply) begin
        if (pend_q) begin
          div_d   = sh_div_q;
          phase_d = sh_phase_q;
          en_d    = sh_en_q;
        end
        pend_d = 1'b0;
        if (!en_d) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (phase_d != '0) begin
          state_d = ST_DELAY;
          cnt_d   = phase_d - DIV_W'(1);
        end else begin
          state_d = ST_RUN;
          show    = 1'b1;
          cnt_d   = DIV_W'(1);
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            show  = 1'b1;
            pos   = cnt_q;
            cnt_d = (cnt_q == div_q - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
          end
          ST_DELAY: begin
            if (cnt_q == '0) begin
              state_d = ST_RUN;
              show    = 1'b1;
              cnt_d   = DIV_W'(1);
            end else begin
              cnt_d = cnt_q - DIV_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      if (acc) pend_d = 1'b1;
      half   = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;
      clk_d  = show && ({1'b0, pos} < half);
      tick_d = show && (pos == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q    <= RESET_EN_MASK[i] ? ST_RUN : ST_IDLE;
        cnt_q      <= '0;
        div_q      <= DIV_W'(DEFAULT_DIV);
        phase_q    <= '0;
        en_q       <= RESET_EN_MASK[i];
        sh_div_q   <= DIV_W'(DEFAULT_DIV);
        sh_phase_q <= '0;
        sh_en_q    <= RESET_EN_MASK[i];
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        phase_q <= phase_d;
        en_q    <= en_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
        if (acc) begin
          sh_div_q   <= new_div;
          sh_phase_q <= new_phase;
          sh_en_q    <= cfg_en;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clkgen_multi.sv
`default_nettype none
// tb_clkgen_multi: directed config writes; each channel's waveform is modelled as
// an origin edge plus div arithmetic and compared every cycle, with literal spot checks.
module tb_clkgen_multi;
  localparam int             NCH  = 5;
  localparam int             DW   = 8;
  localparam int             CW   = 3;
  localparam logic [NCH-1:0] MASK = 5'b10111;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic [DW-1:0]  cfg_phase = '0;
  logic           cfg_en = 1'b0;
  logic [NCH-1:0] clk_out, tick;
  logic           locked;
`ifdef CLKGEN_SYNC_RESTART_EN
  logic           restart = 1'b0;
`endif

  always #5 clock = ~clock;

  clkgen_multi #(
    .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(2), .RESET_EN_MASK(MASK)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef CLKGEN_SYNC_RESTART_EN
    .restart(restart),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_en(cfg_en),
    .clk_out(clk_out),
    .tick(tick),
    .locked(locked)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Model: an enabled channel's period k starts at edge t0 + k*div; before t0 it is held low.
  int m_t0[NCH], m_div[NCH], m_ph[NCH], m_apply[NCH], s_div[NCH], s_ph[NCH];
  bit m_en[NCH], m_pend[NCH], s_en[NCH];
  bit m_locked = 1'b1;
  bit m_acc, m_go;
  int m_ch, m_cd, m_cp;

  function automatic bit m_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic bit exp_clk(input int c);
    if (!m_en[c] || edge_n < m_t0[c]) return 1'b0;
    return ((edge_n - m_t0[c]) % m_div[c]) < ((m_div[c] + 1) / 2);
  endfunction

  function automatic bit exp_tick(input int c);
    if (!m_en[c] || edge_n < m_t0[c]) return 1'b0;
    return ((edge_n - m_t0[c]) % m_div[c]) == 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_n   = 0;
      m_locked = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        m_t0[c] = 1;  m_div[c] = 2; m_ph[c] = 0; m_en[c] = MASK[c]; m_pend[c] = 1'b0;
        m_apply[c] = 0; s_div[c] = 2; s_ph[c] = 0; s_en[c] = 1'b0;
      end
    end else begin
      edge_n   = edge_n + 1;
      m_locked = 1'b1;
      for (int c = 0; c < NCH; c++) if (m_pend[c]) m_locked = 1'b0;
      m_ch  = int'(cfg_ch);
      m_acc = cfg_valid && m_ready(m_ch);
      for (int c = 0; c < NCH; c++) begin
        m_go = m_pend[c] && (edge_n == m_apply[c]);
`ifdef CLKGEN_SYNC_RESTART_EN
        if (restart) m_go = 1'b1;
`endif
        if (m_go) begin
          if (m_pend[c]) begin
            m_en[c] = s_en[c]; m_div[c] = s_div[c]; m_ph[c] = s_ph[c];
          end
          m_pend[c] = 1'b0;
          m_t0[c]   = edge_n + m_ph[c];
        end
      end
      if (m_acc && m_ch < NCH) begin
        m_cd = (cfg_div < 2) ? 2 : int'(cfg_div);
        m_cp = (int'(cfg_phase) >= m_cd) ? m_cd - 1 : int'(cfg_phase);
        s_div[m_ch] = m_cd; s_ph[m_ch] = m_cp; s_en[m_ch] = cfg_en; m_pend[m_ch] = 1'b1;
        if (!m_en[m_ch] || edge_n + 1 <= m_t0[m_ch])
          m_apply[m_ch] = edge_n + 1;
        else
          m_apply[m_ch] = m_t0[m_ch] + m_div[m_ch] *
                          ((edge_n + 1 - m_t0[m_ch] + m_div[m_ch] - 1) / m_div[m_ch]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, required %0h", name, edge_n, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [NCH-1:0] ec, et;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = exp_clk(c);
      et[c] = exp_tick(c);
    end
    check("clk_out", 32'(clk_out), 32'(ec));
    check("tick", 32'(tick), 32'(et));
    check("locked", 32'(locked), 32'(m_locked));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
  end

  // Drive a request at posedge+2 and hold it until accepted; returns at accept edge + 2.
  task automatic cfg_write(input int ch, input int dv, input int ph, input bit en);
    bit done;
    done = 1'b0;
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_div = DW'(dv); cfg_phase = DW'(ph); cfg_en = en;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      done = cfg_ready;
      @(posedge clock);
      #2;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_write_timeout: ch %0d ready stayed 0 for 40 cycles, required 1", ch);
    end
  endtask

  task automatic count_high(input int ch, input int edges, output int ones, output int ticks);
    ones = 0; ticks = 0;
    for (int k = 0; k < edges; k++) begin
      @(posedge clock);
      #1;
      ones  += int'(clk_out[ch]);
      ticks += int'(tick[ch]);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    int ones, ticks, first;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("lit_reset_clk", 32'(clk_out), 32'd0);
    check("lit_reset_locked", 32'(locked), 32'd1);
    check("lit_reset_ready", 32'(cfg_ready), 32'd1);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check("lit_edge1_clk", 32'(clk_out), 32'(MASK));
    check("lit_edge1_tick", 32'(tick), 32'(MASK));
    @(posedge clock); #1;
    check("lit_edge2_clk", 32'(clk_out), 32'd0);
    #1;
    count_high(0, 8, ones, ticks);
    check("lit_div2_high", 32'(ones), 32'd4);
    check("lit_div2_tick", 32'(ticks), 32'd4);

    cfg_write(1, 5, 0, 1'b1);
    idle(12);
    count_high(1, 10, ones, ticks);
    check("lit_div5_high", 32'(ones), 32'd6);
    check("lit_div5_tick", 32'(ticks), 32'd2);

    cfg_write(2, 2, 0, 1'b0);
    check("lit_ch2_stall", 32'(cfg_ready), 32'd0);
    cfg_write(2, 6, 1, 1'b0);
    idle(6);
    count_high(2, 8, ones, ticks);
    check("lit_ch2_stopped", 32'(ones), 32'd0);

    cfg_write(3, 4, 3, 1'b1);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(posedge clock); #1;
      if (clk_out[3]) first = k;
    end
    check("lit_ch3_first_rise", 32'(first), 32'd4);
    #1;
    count_high(3, 8, ones, ticks);
    check("lit_ch3_high", 32'(ones), 32'd4);
    check("lit_ch3_tick", 32'(ticks), 32'd2);

    cfg_write(0, 1, 9, 1'b1);
    idle(6);
    count_high(0, 8, ones, ticks);
    check("lit_ch0_clamped", 32'(ones), 32'd4);

    cfg_ch = 3'd7;
    #1 check("lit_oob_ready", 32'(cfg_ready), 32'd1);
    #1;
    idle(1);
    cfg_write(7, 3, 0, 1'b0);
    cfg_write(5, 3, 0, 1'b0);
    idle(4);

    cfg_write(4, 3, 2, 1'b1);
    idle(5);
    cfg_write(4, 0, 0, 1'b1);
    idle(3);
    cfg_write(4, 7, 200, 1'b1);
    for (int k = 0; k < 5; k++) begin
      idle(k);
      cfg_write(1, 3 + k, k % 2, 1'b1);
    end
    idle(20);

`ifdef CLKGEN_SYNC_RESTART_EN
    cfg_write(0, 3, 0, 1'b1);
    cfg_write(1, 4, 0, 1'b1);
    idle(7);
    restart = 1'b1;
    @(posedge clock); #1;
    check("lit_restart_tick", 32'(tick[1:0]), 32'd3);
    #1 restart = 1'b0;
    idle(12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
